// File: rtl/psram_slv_pkg.sv
// psram_slv_pkg -- shared definitions for the PSRAM slave responder.
// Holds the FSM state encoding, the two supported opcodes and the number of
// address bytes that follow the command phase.
package psram_slv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_LAT    = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } psram_state_e;

    localparam logic [7:0] OPC_READ   = 8'h00;
    localparam logic [7:0] OPC_WRITE  = 8'h80;
    localparam logic [7:0] ADDR_BYTES = 8'd4;

endpackage

// File: rtl/psram_slv_mem.sv
// psram_slv_mem -- byte array behind the PSRAM responder.
// Ports:
//   clk_i    : clock for the write port
//   we_i     : write enable
//   waddr_i  : write byte address
//   wdata_i  : write byte
//   raddr_i  : read byte address (combinational read)
//   rdata_o  : read byte
// Contents have no reset so that data survives a responder reset.
module psram_slv_mem #(
    parameter int MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [MEM_AW-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_r [0:(2**MEM_AW)-1];

    // Synchronous byte write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/psram_slv_resp.sv
// psram_slv_resp -- oversampled PSRAM slave responder (x8 DDR-style bus).
// All bus pins are synchronised into clk_i; each sck transition is one bus
// byte. A transaction is: opcode edge, one dummy edge, four address edges
// (MSB first), 2*LAT latency edges, then data edges until ce rises.
// Ports:
//   clk_i, rst_i        : oversampling clock, synchronous active-high reset
//   psram_sck_i         : bus clock from the controller
//   psram_ce_i          : chip enable, active low
//   psram_io_i          : DQ bus as sampled
//   psram_io_o/_en_o    : DQ drive value and per-bit enable
//   psram_dqs_i         : write data mask (only with PSRAM_SLV_DM_EN)
//   psram_dqs_o/_en_o   : read strobe and its enable
// Build option: define PSRAM_SLV_DM_EN to honour the write data mask.
module psram_slv_resp
    import psram_slv_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int LAT    = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_i,
    output logic [7:0] psram_io_o,
    output logic [7:0] psram_io_en_o,
    input  logic       psram_dqs_i,
    output logic       psram_dqs_o,
    output logic       psram_dqs_en_o
);

    localparam logic [7:0]        LAT_EDGES = 8'(2 * LAT);
    localparam logic [MEM_AW-1:0] ADDR_ONE  = {{(MEM_AW-1){1'b0}}, 1'b1};

    logic         sck_q1_r, sck_q2_r, sck_q3_r;
    logic         ce_q1_r, ce_q2_r;
    logic [7:0]   io_q1_r, io_q2_r;
    logic         dm_s;

    psram_state_e state_r, state_nxt_s;
    logic [7:0]   cnt_r, cnt_nxt_s;
    logic [7:0]   opcode_r, opcode_nxt_s;
    logic [MEM_AW-1:0] addr_r, addr_nxt_s;
    logic [MEM_AW+7:0] addr_cat_s;
    logic         armed_r;
    logic [7:0]   io_o_r, io_nxt_s;
    logic [7:0]   io_en_r, io_en_nxt_s;
    logic         dqs_o_r, dqs_nxt_s;
    logic         dqs_en_r, dqs_en_nxt_s;
    logic         edge_s;
    logic         mem_we_s;
    logic [7:0]   mem_rdata_s;

`ifdef PSRAM_SLV_DM_EN
    logic dqs_q1_r, dqs_q2_r;

    // Data-mask synchroniser, aligned with the sck/io pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dqs_q1_r <= 1'b0;
            dqs_q2_r <= 1'b0;
        end else begin
            dqs_q1_r <= psram_dqs_i;
            dqs_q2_r <= dqs_q1_r;
        end
    end

    assign dm_s = dqs_q2_r;
`else
    logic unused_dqs_s;

    assign unused_dqs_s = psram_dqs_i;
    assign dm_s         = 1'b0;
`endif

    // Two-flop synchronisers plus the previous sck for edge detection.
    // ce resets to 0 so that a reset never looks like a ce-high period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q1_r <= 1'b0;
            sck_q2_r <= 1'b0;
            sck_q3_r <= 1'b0;
            ce_q1_r  <= 1'b0;
            ce_q2_r  <= 1'b0;
            io_q1_r  <= 8'h00;
            io_q2_r  <= 8'h00;
        end else begin
            sck_q1_r <= psram_sck_i;
            sck_q2_r <= sck_q1_r;
            sck_q3_r <= sck_q2_r;
            ce_q1_r  <= psram_ce_i;
            ce_q2_r  <= ce_q1_r;
            io_q1_r  <= psram_io_i;
            io_q2_r  <= io_q1_r;
        end
    end

    assign edge_s     = sck_q2_r ^ sck_q3_r;
    assign addr_cat_s = {addr_r, io_q2_r};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        opcode_nxt_s = opcode_r;
        addr_nxt_s   = addr_r;
        io_nxt_s     = io_o_r;
        io_en_nxt_s  = 8'h00;
        dqs_nxt_s    = 1'b0;
        dqs_en_nxt_s = 1'b0;
        mem_we_s     = 1'b0;
        if (ce_q2_r) begin
            // ce high wins over any coincident sck edge.
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Only start after ce has been seen high since reset.
                    if (armed_r) begin
                        state_nxt_s = ST_CMD;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (edge_s) begin
                        if (cnt_r == 8'd0) begin
                            opcode_nxt_s = io_q2_r;
                            cnt_nxt_s    = 8'd1;
                        end else begin
                            cnt_nxt_s = 8'd0;
                            if ((opcode_r == OPC_READ) || (opcode_r == OPC_WRITE)) begin
                                state_nxt_s = ST_ADDR;
                            end else begin
                                state_nxt_s = ST_IGNORE;
                            end
                        end
                    end else begin
                        state_nxt_s = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (edge_s) begin
                        addr_nxt_s = addr_cat_s[MEM_AW-1:0];
                        if (cnt_r == ADDR_BYTES - 8'd1) begin
                            cnt_nxt_s   = 8'd0;
                            state_nxt_s = ST_LAT;
                        end else begin
                            cnt_nxt_s = cnt_r + 8'd1;
                        end
                    end else begin
                        state_nxt_s = ST_ADDR;
                    end
                end
                ST_LAT: begin
                    if (edge_s) begin
                        if (cnt_r == LAT_EDGES - 8'd1) begin
                            cnt_nxt_s = 8'd0;
                            if (opcode_r == OPC_READ) begin
                                // Last latency edge launches the first byte so it
                                // is valid for the controller's next sampling edge.
                                state_nxt_s  = ST_RDATA;
                                io_nxt_s     = mem_rdata_s;
                                io_en_nxt_s  = 8'hFF;
                                dqs_nxt_s    = 1'b1;
                                dqs_en_nxt_s = 1'b1;
                                addr_nxt_s   = addr_r + ADDR_ONE;
                            end else begin
                                state_nxt_s = ST_WDATA;
                            end
                        end else begin
                            cnt_nxt_s = cnt_r + 8'd1;
                        end
                    end else begin
                        state_nxt_s = ST_LAT;
                    end
                end
                ST_RDATA: begin
                    io_en_nxt_s  = 8'hFF;
                    dqs_en_nxt_s = 1'b1;
                    if (edge_s) begin
                        io_nxt_s   = mem_rdata_s;
                        dqs_nxt_s  = ~dqs_o_r;
                        addr_nxt_s = addr_r + ADDR_ONE;
                    end else begin
                        dqs_nxt_s = dqs_o_r;
                    end
                end
                ST_WDATA: begin
                    if (edge_s) begin
                        mem_we_s   = ~dm_s;
                        addr_nxt_s = addr_r + ADDR_ONE;
                    end else begin
                        state_nxt_s = ST_WDATA;
                    end
                end
                ST_IGNORE: begin
                    state_nxt_s = ST_IGNORE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end
    end

    // FSM state, datapath registers and registered bus outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            opcode_r <= 8'h00;
            addr_r   <= {MEM_AW{1'b0}};
            armed_r  <= 1'b0;
            io_o_r   <= 8'h00;
            io_en_r  <= 8'h00;
            dqs_o_r  <= 1'b0;
            dqs_en_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            opcode_r <= opcode_nxt_s;
            addr_r   <= addr_nxt_s;
            armed_r  <= armed_r | ce_q2_r;
            io_o_r   <= io_nxt_s;
            io_en_r  <= io_en_nxt_s;
            dqs_o_r  <= dqs_nxt_s;
            dqs_en_r <= dqs_en_nxt_s;
        end
    end

    psram_slv_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we_s & ~rst_i),
        .waddr_i (addr_r),
        .wdata_i (io_q2_r),
        .raddr_i (addr_r),
        .rdata_o (mem_rdata_s)
    );

    assign psram_io_o     = io_o_r;
    assign psram_io_en_o  = io_en_r;
    assign psram_dqs_o    = dqs_o_r;
    assign psram_dqs_en_o = dqs_en_r;

endmodule
